perceptron_uart_n: RTL and testbench

//  N-input perceptron with one multiplier, controlled over a byte-wide UART.

---
 rtl/perceptron_uart_n.sv | 218 +++++++++++++++++++++
 tb/tb_perceptron_uart_n.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/perceptron_uart_n.sv
// N-input perceptron (one multiplier, signed 8-bit weights plus bias) driven by a byte-wide 8N1 UART.
// Commands: WRITE weights, EVAL, TRAIN (perceptron rule with saturation), READ weights.
module perceptron_uart_n #(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned LR_SHIFT = 0
) (
  input  logic clk,
  input  logic nRst,
  input  logic rx,
  output logic tx,
  output logic busy,
  output logic y
);
  localparam int unsigned ACC_W  = 16 + $clog2(N_IN + 1);
  localparam int unsigned CNT_W  = $clog2(BAUD_DIV + 1);
  localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN + 1) : 1;
  localparam int unsigned LEFT_W = $clog2(N_IN + 2);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_W   = IDX_W'(N_IN);
  localparam logic [IDX_W-1:0] LAST_X   = IDX_W'(N_IN - 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_EVAL  = 8'h02;
  localparam logic [7:0] OP_TRAIN = 8'h03;
  localparam logic [7:0] OP_READ  = 8'h04;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPS  = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;

  // UART receiver: synchroniser, start-bit recheck at half bit, mid-bit sampling
  logic             r_rx_s1, r_rx_s2, r_rx_prev, r_rx_on, r_rx_vld, r_rx_ferr;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [3:0]       r_rx_bit;
  logic [7:0]       r_rx_sh;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_on <= 1'b0; r_rx_vld <= 1'b0; r_rx_ferr <= 1'b0;
      r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_sh <= '0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_vld  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (!r_rx_on) begin
        if (r_rx_prev && !r_rx_s2) begin
          r_rx_on <= 1'b1; r_rx_cnt <= '0; r_rx_bit <= '0;
        end
      end else if (r_rx_bit == 4'd0) begin
        if (r_rx_cnt == HALF_END) begin
          r_rx_cnt <= '0;
          if (r_rx_s2) r_rx_on <= 1'b0;
          else         r_rx_bit <= 4'd1;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
      end else if (r_rx_cnt == BIT_END) begin
        r_rx_cnt <= '0;
        if (r_rx_bit == 4'd9) begin
          r_rx_on <= 1'b0; r_rx_vld <= r_rx_s2; r_rx_ferr <= !r_rx_s2;
        end else begin
          r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]}; r_rx_bit <= r_rx_bit + 4'd1;
        end
      end else r_rx_cnt <= r_rx_cnt + 1'b1;
    end
  end

  logic [2:0]        r_state, w_state_nx;
  logic [7:0]        r_op, r_reply;
  logic [IDX_W-1:0]  r_idx;
  logic [LEFT_W-1:0] r_tx_left;
  logic              r_from_w, r_busy, r_y, r_upd;
  logic signed [7:0] r_w [0:N_IN];
  logic signed [7:0] r_x [0:N_IN];
  logic signed [ACC_W-1:0] r_acc;
  logic [9:0]        r_tx_sh;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [3:0]        r_tx_bit;
  logic              r_tx_on;

  logic [IDX_W-1:0]  w_last_op, w_mi, w_xi;
  logic signed [15:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_nx;
  logic              w_y_nx, w_t, w_tx_done, w_tx_load;
  logic signed [7:0] w_dx;
  logic signed [9:0] w_sum;
  logic [7:0]        w_tx_byte;

  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'h7F;
    else if (v < -10'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  assign w_last_op = (r_op == OP_EVAL) ? LAST_X : LAST_W;
  assign w_mi      = r_idx + 1'b1;
  assign w_xi      = (r_idx == '0) ? '0 : r_idx - 1'b1;
  assign w_prod    = 16'(r_w[w_mi]) * 16'(r_x[r_idx]);
  assign w_acc_nx  = r_acc + ACC_W'(w_prod);
  assign w_y_nx    = !w_acc_nx[ACC_W-1] && (w_acc_nx != '0);
  assign w_t       = (r_x[N_IN] != 8'sd0);
  // Training step: bias moves by one, weights by the shifted input
  assign w_dx      = (r_idx == '0) ? 8'sd1 : (r_x[w_xi] >>> LR_SHIFT);
  assign w_sum     = 10'(r_w[r_idx]) + (w_t ? 10'(w_dx) : -10'(w_dx));
  assign w_tx_done = r_tx_on && (r_tx_bit == 4'd9) && (r_tx_cnt == BIT_END);
  assign w_tx_load = (r_state == S_SEND) && (!r_tx_on || w_tx_done) && (r_tx_left != '0);
  assign w_tx_byte = r_from_w ? r_w[r_idx] : r_reply;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_rx_vld)
          w_state_nx = (r_rx_sh inside {OP_WRITE, OP_EVAL, OP_TRAIN}) ? S_OPS : S_SEND;
        else if (r_rx_ferr)
          w_state_nx = S_SEND;
      end
      S_OPS: begin
        if (r_rx_ferr) w_state_nx = S_SEND;
        else if (r_rx_vld && r_idx == w_last_op)
          w_state_nx = (r_op == OP_WRITE) ? S_SEND : S_MAC;
      end
      S_MAC:  if (r_idx == LAST_X) w_state_nx = (r_op == OP_TRAIN) ? S_UPD : S_SEND;
      S_UPD:  if (r_idx == LAST_W) w_state_nx = S_SEND;
      S_SEND: if (w_tx_done && r_tx_left == '0) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_op <= '0; r_reply <= '0; r_idx <= '0; r_tx_left <= '0;
      r_from_w <= 1'b0; r_busy <= 1'b0; r_y <= 1'b0; r_upd <= 1'b0; r_acc <= '0;
      for (int i = 0; i <= int'(N_IN); i++) begin
        r_w[i] <= '0; r_x[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rx_vld || r_rx_ferr) begin
            r_busy <= 1'b1; r_op <= r_rx_sh; r_idx <= '0;
            r_reply <= 8'hEE; r_tx_left <= LEFT_W'(1); r_from_w <= 1'b0;
            if (r_rx_vld && r_rx_sh == OP_READ) begin
              r_tx_left <= LEFT_W'(N_IN + 1); r_from_w <= 1'b1;
            end
          end
        end
        S_OPS: begin
          if (r_rx_ferr) begin
            r_reply <= 8'hEE; r_idx <= '0;
          end else if (r_rx_vld) begin
            r_x[r_idx] <= r_rx_sh;
            r_idx      <= r_idx + 1'b1;
            if (r_idx == w_last_op) begin
              r_idx   <= '0;
              r_acc   <= ACC_W'(r_w[0]);
              r_reply <= 8'hAA;
              if (r_op == OP_WRITE)
                for (int i = 0; i <= int'(N_IN); i++)
                  r_w[i] <= (i == int'(N_IN)) ? r_rx_sh : r_x[i];
            end
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nx;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_X) begin
            r_idx   <= '0;
            r_y     <= w_y_nx;
            r_upd   <= (w_y_nx != w_t);
            r_reply <= (r_op == OP_TRAIN) ? {6'b0, w_y_nx != w_t, w_y_nx} : {7'b0, w_y_nx};
          end
        end
        S_UPD: begin
          if (r_upd) r_w[r_idx] <= sat8(w_sum);
          r_idx <= (r_idx == LAST_W) ? '0 : r_idx + 1'b1;
        end
        S_SEND: begin
          if (w_tx_load) begin
            r_tx_left <= r_tx_left - 1'b1;
            if (r_tx_left != LEFT_W'(1)) r_idx <= r_idx + 1'b1;
          end else if (w_tx_done && r_tx_left == '0) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // UART transmitter; next byte loads on the last stop-bit clock so frames abut
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_tx_sh <= '1; r_tx_cnt <= '0; r_tx_bit <= '0; r_tx_on <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_sh <= {1'b1, w_tx_byte, 1'b0}; r_tx_cnt <= '0; r_tx_bit <= '0; r_tx_on <= 1'b1;
    end else if (r_tx_on) begin
      if (r_tx_cnt == BIT_END) begin
        r_tx_cnt <= '0;
        r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
        if (r_tx_bit == 4'd9) r_tx_on <= 1'b0;
        else                  r_tx_bit <= r_tx_bit + 4'd1;
      end else r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  assign tx   = r_tx_sh[0];
  assign busy = r_busy;
  assign y    = r_y;
endmodule

// File: tb/tb_perceptron_uart_n.sv
// Directed bench for perceptron_uart_n: drives UART commands on rx and decodes replies on tx.
module tb_perceptron_uart_n;
  localparam int unsigned N_IN     = 4;
  localparam int unsigned BAUD_DIV = 16;
  localparam int unsigned LR_SHIFT = 0;
  localparam int BIT_NS = BAUD_DIV * 10;

  logic clk = 1'b0;
  logic nRst = 1'b1;
  logic rx = 1'b1;
  logic tx, busy, y;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] rxq[$];
  logic [7:0] mon_b;

  perceptron_uart_n #(.N_IN(N_IN), .BAUD_DIV(BAUD_DIV), .LR_SHIFT(LR_SHIFT)) dut (
    .clk(clk), .nRst(nRst), .rx(rx), .tx(tx), .busy(busy), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Reply decoder: samples tx mid-bit, offset from the clock edges
  initial forever begin
    @(negedge tx);
    #(BIT_NS / 2 + 2);
    if (tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        mon_b[i] = tx;
      end
      #(BIT_NS);
      check("tx_stop_bit", {7'b0, tx}, 8'h01);
      rxq.push_back(mon_b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop;
    #(BIT_NS);
    rx = 1'b1;
  endtask

  task automatic cmd(input logic [7:0] op, input int n, input logic [7:0] a0, a1, a2, a3, a4);
    logic [7:0] a [5];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4;
    send_byte(op, 1'b1);
    for (int i = 0; i < n; i++) send_byte(a[i], 1'b1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    for (int c = 0; c < 30 * BAUD_DIV && rxq.size() == 0; c++) @(posedge clk);
    if (rxq.size() == 0) check({tag, "_timeout"}, 8'hxx, exp);
    else                 check(tag, rxq.pop_front(), exp);
  endtask

  task automatic expect_n(input string tag, input int n, input logic [7:0] e0, e1, e2, e3, e4);
    logic [7:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int i = 0; i < n; i++) expect_byte(tag, e[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 40 * BAUD_DIV && busy !== 1'b0; c++) @(posedge clk);
    check(tag, {7'b0, busy}, 8'h00);
    #(2 * BIT_NS);
  endtask

  initial begin
    #1 nRst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tx_during_reset", {7'b0, tx}, 8'h01);
    end
    check("busy_reset", {7'b0, busy}, 8'h00);
    check("y_reset", {7'b0, y}, 8'h00);
    nRst = 1'b1;
    #(2 * BIT_NS);

    // READ after reset: bias and all weights zero
    cmd(8'h04, 0, 0, 0, 0, 0, 0);
    check("busy_after_opcode", {7'b0, busy}, 8'h01);
    expect_n("read_reset", 5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle("idle_read0");

    cmd(8'h01, 5, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01);
    expect_byte("write_ack", 8'hAA);
    wait_idle("idle_write1");
    // 1+2+3-7 = -1
    cmd(8'h02, 4, 8'h01, 8'h02, 8'h03, 8'hF9, 0);
    expect_byte("eval_neg", 8'h00);
    wait_idle("idle_eval_neg");
    check("y_neg", {7'b0, y}, 8'h00);
    // 1+2+3-5 = 1
    cmd(8'h02, 4, 8'h01, 8'h02, 8'h03, 8'hFB, 0);
    expect_byte("eval_pos", 8'h01);
    wait_idle("idle_eval_pos");
    check("y_pos", {7'b0, y}, 8'h01);
    // 1+2+3-6 = 0 -> y=0
    cmd(8'h02, 4, 8'h01, 8'h02, 8'h03, 8'hFA, 0);
    expect_byte("eval_zero", 8'h00);
    wait_idle("idle_eval_zero");
    check("y_zero", {7'b0, y}, 8'h00);

    nRst = 1'b0;
    #20 nRst = 1'b1;
    #(2 * BIT_NS);
    // acc=0 -> y=0, t=1 -> upd: bias 1, w0 10
    cmd(8'h03, 5, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h01);
    expect_byte("train1", 8'h02);
    wait_idle("idle_train1");
    cmd(8'h04, 0, 0, 0, 0, 0, 0);
    expect_n("read_train1", 5, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h00);
    wait_idle("idle_read1");
    // acc=1+100 -> y=1, no update
    cmd(8'h03, 5, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h01);
    expect_byte("train2", 8'h01);
    wait_idle("idle_train2");
    cmd(8'h04, 0, 0, 0, 0, 0, 0);
    expect_n("read_train2", 5, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h00);
    wait_idle("idle_read2");

    // acc = 120*20 - 128*100 < 0; w0 140->127, w1 -28, bias 1
    cmd(8'h01, 5, 8'h00, 8'h78, 8'h80, 8'h00, 8'h00);
    expect_byte("write_sat", 8'hAA);
    wait_idle("idle_write_sat");
    cmd(8'h03, 5, 8'h14, 8'h64, 8'h00, 8'h00, 8'h01);
    expect_byte("train_sat", 8'h02);
    wait_idle("idle_train_sat");
    cmd(8'h04, 0, 0, 0, 0, 0, 0);
    expect_n("read_sat", 5, 8'h01, 8'h7F, 8'hE4, 8'h00, 8'h00);
    wait_idle("idle_read_sat");

    cmd(8'h55, 0, 0, 0, 0, 0, 0);
    expect_byte("bad_opcode", 8'hEE);
    wait_idle("idle_bad_op");

    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    expect_byte("framing_err", 8'hEE);
    wait_idle("idle_framing");
    cmd(8'h04, 0, 0, 0, 0, 0, 0);
    expect_n("read_after_ferr", 5, 8'h01, 8'h7F, 8'hE4, 8'h00, 8'h00);
    wait_idle("idle_read_ferr");

    // Reset in the middle of EVAL operand 2
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    #(2 * BIT_NS);
    nRst = 1'b0;
    rx = 1'b1;
    #20 nRst = 1'b1;
    #(40 * BIT_NS);
    check("no_reply_after_reset", 8'(rxq.size()), 8'h00);
    check("busy_after_reset", {7'b0, busy}, 8'h00);
    check("tx_after_reset", {7'b0, tx}, 8'h01);

    cmd(8'h01, 5, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01);
    expect_byte("write_post_rst", 8'hAA);
    wait_idle("idle_write_post_rst");
    cmd(8'h02, 4, 8'h01, 8'h02, 8'h03, 8'hFB, 0);
    expect_byte("eval_post_rst", 8'h01);
    wait_idle("idle_eval_post_rst");
    check("y_post_rst", {7'b0, y}, 8'h01);
    check("no_stray_bytes", 8'(rxq.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
